// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack sequencer and the PC mux: state encoding,
// pc_src codes, default interrupt vector, and the Moore output decode.
package stack_sequencer_pkg;

  localparam logic [15:0] VECTOR_ADDR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_VEC  = 2'b01,
    PC_MEM  = 2'b10,
    PC_CALL = 2'b11
  } pc_src_e;

  typedef enum logic [2:0] {
    IDLE,
    INT_PC,
    INT_CCR,
    INT_VEC,
    CALL_PUSH,
    RET_POP,
    RTI_CCR,
    RTI_PC
  } state_e;

  typedef struct packed {
    logic    push;
    logic    pop;
    logic    push_pc;
    logic    push_ccr;
    logic    stall;
    pc_src_e pc_src;
    logic    pc_write;
    logic    ccr_write;
    logic    int_ack;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c       = '0;
    c.stall = (s != IDLE);
    case (s)
      INT_PC:    begin c.push = 1'b1; c.push_pc = 1'b1; c.int_ack = 1'b1; end
      INT_CCR:   begin c.push = 1'b1; c.push_ccr = 1'b1; end
      INT_VEC:   begin c.pc_src = PC_VEC; c.pc_write = 1'b1; end
      CALL_PUSH: begin c.push = 1'b1; c.push_pc = 1'b1; c.pc_src = PC_CALL; c.pc_write = 1'b1; end
      RET_POP:   begin c.pop = 1'b1; c.pc_src = PC_MEM; c.pc_write = 1'b1; end
      RTI_CCR:   begin c.pop = 1'b1; c.ccr_write = 1'b1; end
      RTI_PC:    begin c.pop = 1'b1; c.pc_src = PC_MEM; c.pc_write = 1'b1; end
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stack_sequencer_depth_counter.sv
// Outstanding stack-frame counter: saturates at 0 and MAX_DEPTH and reports
// whether one (call) or two (interrupt) more pushes still fit.
module stack_depth_counter #(
  parameter int MAX_DEPTH = 16,
  localparam int DW = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [DW-1:0] depth_o,
  output logic          call_room_o,
  output logic          int_room_o
);

  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);

  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (inc_i && !dec_i && depth_q != DMAX)
      depth_d = depth_q + DW'(1);
    else if (dec_i && !inc_i && depth_q != '0)
      depth_d = depth_q - DW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  assign depth_o     = depth_q;
  assign call_room_o = (32'(depth_q) + 32'd1) <= 32'(MAX_DEPTH);
  assign int_room_o  = (32'(depth_q) + 32'd2) <= 32'(MAX_DEPTH);

endmodule

// File: rtl/stack_sequencer.sv
// Memory-stage stack sequencer for CALL/RET/RTI and interrupt entry; all
// outputs are registered and decoded from the state being entered.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter logic [15:0] VECTOR_ADDR = VECTOR_ADDR_DEF,
  parameter int          MAX_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       call_req,
  input  logic       ret_req,
  input  logic       rti_req,
  output logic       push,
  output logic       pop,
  output logic       pushPc,
  output logic       pushCCR,
  output logic       stall,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ccr_write,
  output logic       int_ack,
  output logic       overflow
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  state_e        state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          ovf_q, ovf_d;
  logic          pending_q, pending_d;
  logic          refused_q, refused_d;
  logic          int_prev_q;
  logic          int_want;
  logic          call_room, int_room;
  logic [DW-1:0] depth;

  stack_depth_counter #(.MAX_DEPTH(MAX_DEPTH)) u_depth (
    .clk_i      (clk),
    .rst_i      (rst),
    .inc_i      (ctrl_q.push),
    .dec_i      (ctrl_q.pop),
    .depth_o    (depth),
    .call_room_o(call_room),
    .int_room_o (int_room)
  );

  assign int_want = int_req | pending_q;

  always_comb begin
    state_d   = state_q;
    ovf_d     = 1'b0;
    refused_d = refused_q;
    pending_d = pending_q | (int_req & ~int_prev_q);
    case (state_q)
      IDLE: begin
        if (int_want && int_room) begin
          state_d = INT_PC;
        end else begin
          // A refused interrupt stays pending but must not block RET/RTI,
          // otherwise the stack could never drain; overflow fires once per refusal.
          if (int_want) begin
            pending_d = 1'b1;
            ovf_d     = ~refused_q;
            refused_d = 1'b1;
          end
          if (rti_req)       state_d = RTI_CCR;
          else if (ret_req)  state_d = RET_POP;
          else if (call_req) begin
            if (call_room) state_d = CALL_PUSH;
            else           ovf_d   = 1'b1;
          end
        end
      end
      INT_PC:  state_d = INT_CCR;
      INT_CCR: state_d = INT_VEC;
      RTI_CCR: state_d = RTI_PC;
      default: state_d = IDLE;
    endcase
    if (state_d == INT_PC) begin
      pending_d = 1'b0;
      refused_d = 1'b0;
    end
    ctrl_d = state_ctrl(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      pending_q  <= 1'b0;
      refused_q  <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      pending_q  <= pending_d;
      refused_q  <= refused_d;
      int_prev_q <= int_req;
    end
  end

  assign push      = ctrl_q.push;
  assign pop       = ctrl_q.pop;
  assign pushPc    = ctrl_q.push_pc;
  assign pushCCR   = ctrl_q.push_ccr;
  assign stall     = ctrl_q.stall;
  assign pc_src    = ctrl_q.pc_src;
  assign pc_write  = ctrl_q.pc_write;
  assign ccr_write = ctrl_q.ccr_write;
  assign int_ack   = ctrl_q.int_ack;
  assign overflow  = ovf_q;

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter VECTOR_ADDR, default 16'h0000, meaning the PC value loaded on interrupt entry.
REQ-002 SHALL have parameter MAX_DEPTH, default 16, meaning the maximum outstanding stack frames (interrupt frames count as 2).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state updates on the posedge.
REQ-004 SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port int_req  input  1  meaning an external interrupt request level.
REQ-006 SHALL have ports call_req, ret_req, rti_req  input  1 each  meaning decoded CALL/RET/RTI in the memory stage.
REQ-007 SHALL have ports push, pop, pushPc, pushCCR  output  1 each  meaning they drive the memory stage controls of the same names.
REQ-008 SHALL have port stall  output  1  meaning freeze fetch/decode/execute.
REQ-009 SHALL have port pc_src  output  2  meaning 00 hold/normal, 01 VECTOR_ADDR, 10 memory read data, 11 call target.
REQ-010 SHALL have ports pc_write, ccr_write, int_ack, overflow  output  1 each  meaning PC load, flag-register restore from memory, interrupt accepted, and push refused at full depth.

Function
REQ-011 SHALL implement FSM states IDLE, INT_PC, INT_CCR, INT_VEC, CALL_PUSH, RET_POP, RTI_CCR, RTI_PC; outputs are Moore (decoded from state only).
REQ-012 In IDLE, SHALL select one request per posedge with priority int_req > rti_req > ret_req > call_req.
REQ-013 Interrupt path SHALL be IDLE->INT_PC->INT_CCR->INT_VEC->IDLE: push+pushPc, then push+pushCCR, then pc_src=01 with pc_write; int_ack high only in INT_PC.
REQ-014 CALL_PUSH SHALL assert push+pushPc, pc_src=11, pc_write for one cycle, then return to IDLE.
REQ-015 RET_POP SHALL assert pop, pc_src=10, pc_write for one cycle, then return to IDLE.
REQ-016 RTI path SHALL be RTI_CCR (pop, ccr_write) -> RTI_PC (pop, pc_src=10, pc_write) -> IDLE.
REQ-017 stall SHALL be high in every non-IDLE state and low in IDLE.
REQ-018 push and pop SHALL never be high in the same cycle; pushPc and pushCCR SHALL never be high together.
REQ-019 An int_req rising during a sequence SHALL be latched in a pending flag and serviced from IDLE before any other request; pending SHALL clear on entry to INT_PC.
REQ-020 SHALL keep a depth counter (width clog2(MAX_DEPTH+1)) incremented per push and decremented per pop.
REQ-021 A call or interrupt with depth > MAX_DEPTH-required_pushes SHALL NOT be started, SHALL pulse overflow for one cycle and SHALL stay in IDLE; an interrupt stays pending.
REQ-022 RET/RTI at depth 0 SHALL still execute (underflow is not detected) and the depth counter SHALL saturate at 0, never wrapping.

Reset
REQ-023 rst SHALL force IDLE, depth=0, pending=0, and all outputs 0 (pc_src=00) on the next posedge, including mid-sequence.
REQ-024 rst SHALL take precedence over every request in the same cycle.

Structure
REQ-025 The state encoding, the pc_src codes and VECTOR_ADDR default SHALL live in a shared package used by this block and the PC mux.
REQ-026 The depth counter with its saturate/full logic SHALL be the single sub-module stack_depth_counter.

Verification
REQ-027 int_req=1 in IDLE at cycle 0 -> cycles 1-3: INT_PC (push,pushPc,int_ack), INT_CCR (push,pushCCR), INT_VEC (pc_src=01, pc_write); stall=1 in cycles 1-3; depth=2.
REQ-028 call_req then ret_req -> one push+pushPc cycle, then one pop cycle with pc_src=10; depth 0->1->0.
REQ-029 int_req and call_req asserted together -> interrupt sequence first; call is not started.
REQ-030 int_req pulsed during RTI_CCR -> RTI completes, then INT_PC in the cycle after returning to IDLE.
REQ-031 MAX_DEPTH=2, depth=1, int_req=1 -> overflow pulse, no push, state stays IDLE.
REQ-032 rst asserted in INT_CCR -> next cycle IDLE, all outputs 0, depth=0.
